decode_stage: RTL
=================

# decode_stage

Instruction decode stage of the RV32I pipeline, directly upstream of the register file. Splits the fetched instruction into register addresses (driven combinationally into the register file read ports) and generates the sign-extended immediate. Merges the register-file read data with a same-cycle writeback bypass and registers everything into a single-entry ID/EX output buffer with valid/ready handshake, stall hold and flush.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1  fetch handshake
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- flush  in  1  kill buffered and incoming instruction
- rf_ra1, rf_ra2  out  5  register-file read addresses
- rf_rd1, rf_rd2  in  32  register-file read data (combinational)
- wb_we, wb_wa, wb_wd  in  1/5/32  writeback port, the same signals that drive the register file write port
- out_valid / out_ready  out / in  1  execute handshake
- out_pc, out_imm, out_rs1_val, out_rs2_val  out  32  buffered operands
- out_rs1, out_rs2, out_rd  out  5  buffered register indices
- out_opcode  out  7; out_funct3  out  3; out_funct7  out  7
- out_illegal  out  1  unsupported opcode or instr[1:0] != 2'b11

## Operation
- rf_ra1 = in_instr[19:15], rf_ra2 = in_instr[24:20], always, regardless of in_valid.
- Operand select, per source: index 0 -> 0; else wb_we && wb_wa == index -> wb_wd (bypass, since the register file write lands only at the next edge); else rf_rd.
- Immediate by opcode: I (LOAD, OP-IMM, JALR, SYSTEM) sext(instr[31:20]); S sext({[31:25],[11:7]}); B sext({[31],[7],[30:25],[11:8],0}); U {[31:12],12'b0}; J sext({[31],[19:12],[20],[30:21],0}); OP, MISC-MEM, illegal -> 0.
- Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011. Illegal instructions still pass through with out_illegal = 1.
- in_ready = !flush && (!out_valid || out_ready).
- Capture at the edge when in_valid && in_ready: all out_* fields loaded, out_valid <= 1.
- Drain when out_valid && out_ready and no capture: out_valid <= 0.
- Stall refresh: while out_valid && !out_ready, a writeback with wb_we, wb_wa != 0 and wb_wa == out_rs1 (resp. out_rs2) overwrites out_rs1_val (resp. out_rs2_val) with wb_wd. Both are updated if both match.
- Field extraction is identical for all formats. Operand values for fields a format does not use are don't-care for the consumer but still follow the rules above.

## Timing
- Register-address path is combinational, zero latency. Decode-to-output latency is one cycle.
- Full throughput: back-to-back captures while out_ready = 1.
- Priority order: rst > flush > capture/drain > stall refresh.
- flush: out_valid <= 0 at the next edge, no capture that cycle, in_ready = 0 while flush is high.
- rst: out_valid and every out_* register <= 0 at the next edge. A rst mid-stall discards the held instruction.
- out_* fields are stable whenever out_valid && !out_ready.

## Structure
- riscv_pkg additions: opcode localparams (OP_LUI ... OP_SYSTEM), an imm_fmt_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE), and an id_ex_t struct bundling the out_* fields. Reuse REG_ZERO and RESET_VALUE.
- One sub-module, imm_gen: purely combinational, instr in, imm_fmt_e in, 32-bit imm out.

## Test plan
- Reset, then in_instr 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, out_rd=1, out_imm=0x00000005, out_rs1_val=0, out_illegal=0.
- in_instr 0x002081B3 (add x3,x1,x2), rf_rd1=0x11, rf_rd2=0x22, with wb_we=1, wb_wa=1, wb_wd=0xAA in the same cycle -> out_rs1_val=0xAA, out_rs2_val=0x22.
- 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC; 0x123452B7 (lui x5,0x12345) -> out_imm=0x12345000, out_rd=5.
- Capture add x3,x1,x2, hold out_ready=0, then write wb x2=0x55 -> out_rs2_val=0x55 the next cycle, other fields unchanged, in_ready=0 throughout.
- out_valid=1 with in_valid=1 and flush=1 -> in_ready=0, out_valid=0 next cycle, no capture. Assert rst while stalled -> all outputs 0 next cycle.
- in_instr 0xFFFFFFFF and 0x00000000 -> out_illegal=1, out_imm=0; in_instr 0x00000073 (ecall) -> out_illegal=0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// RV32I decode-stage shared definitions:
// opcodes, immediate formats and the ID/EX bundle.
package decode_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0]      REG_ZERO    = 5'd0;
    localparam logic [XLEN-1:0] RESET_VALUE = '0;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OPIMM    = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            illegal;
    } id_ex_t;

    // Low two bits are part of the opcode, so
    // a compressed encoding never matches here.
    function automatic logic is_legal(
        input logic [6:0] op
    );
        is_legal = (op == OP_LUI)
                || (op == OP_AUIPC)
                || (op == OP_JAL)
                || (op == OP_JALR)
                || (op == OP_BRANCH)
                || (op == OP_LOAD)
                || (op == OP_STORE)
                || (op == OP_OPIMM)
                || (op == OP_OP)
                || (op == OP_MISC_MEM)
                || (op == OP_SYSTEM);
    endfunction

    function automatic imm_fmt_e fmt_of(
        input logic [6:0] op
    );
        fmt_of = IMM_NONE;
        unique case (1'b1)
            (op == OP_LOAD),
            (op == OP_OPIMM),
            (op == OP_JALR),
            (op == OP_SYSTEM): fmt_of = IMM_I;
            (op == OP_STORE):  fmt_of = IMM_S;
            (op == OP_BRANCH): fmt_of = IMM_B;
            (op == OP_LUI),
            (op == OP_AUIPC):  fmt_of = IMM_U;
            (op == OP_JAL):    fmt_of = IMM_J;
            default:           fmt_of = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle
// of the decode stage.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush,
        input  in_ready,
        output out_ready,
        input  out_valid, out_pc, out_imm,
        input  out_rs1_val, out_rs2_val,
        input  out_rs1, out_rs2, out_rd,
        input  out_opcode, out_funct3, out_funct7,
        input  out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush,
        output in_ready,
        input  out_ready,
        output out_valid, out_pc, out_imm,
        output out_rs1_val, out_rs2_val,
        output out_rs1, out_rs2, out_rd,
        output out_opcode, out_funct3, out_funct7,
        output out_illegal
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: reassembles and sign-
// extends the immediate for a given format.
module imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:7]     i_instr,
    input  imm_fmt_e        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    // Format-driven bit shuffle, zero otherwise
    always_comb begin
        o_imm = '0;
        unique case (i_fmt)
            IMM_I: o_imm = {{20{i_instr[31]}},
                            i_instr[31:20]};
            IMM_S: o_imm = {{20{i_instr[31]}},
                            i_instr[31:25],
                            i_instr[11:7]};
            IMM_B: o_imm = {{19{i_instr[31]}},
                            i_instr[31],
                            i_instr[7],
                            i_instr[30:25],
                            i_instr[11:8],
                            1'b0};
            IMM_U: o_imm = {i_instr[31:12],
                            12'b0};
            IMM_J: o_imm = {{11{i_instr[31]}},
                            i_instr[31],
                            i_instr[19:12],
                            i_instr[20],
                            i_instr[30:21],
                            1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode: field split, immediate, bypassed
// operands, single-entry ID/EX buffer.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    decode_stage_if.slave   bus,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wd
);

    logic            r_valid;
    id_ex_t          r_q;

    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [6:0]      w_opcode;
    logic            w_legal;
    imm_fmt_e        w_fmt;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_capture;
    logic            w_stall;
    id_ex_t          w_next;

    assign w_rs1    = bus.in_instr[19:15];
    assign w_rs2    = bus.in_instr[24:20];
    assign w_opcode = bus.in_instr[6:0];
    assign w_legal  = is_legal(w_opcode);
    assign w_fmt    = w_legal ? fmt_of(w_opcode)
                              : IMM_NONE;

    assign rf_ra1 = w_rs1;
    assign rf_ra2 = w_rs2;

    imm_gen u_imm_gen (
        .i_instr (bus.in_instr[31:7]),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm)
    );

    // Operand select: x0, then same-cycle
    // writeback (RF write not yet landed), then RF
    always_comb begin
        w_rs1_val = rf_rd1;
        w_rs2_val = rf_rd2;
        if (w_rs1 == REG_ZERO)
            w_rs1_val = RESET_VALUE;
        else if (wb_we && wb_wa == w_rs1)
            w_rs1_val = wb_wd;
        if (w_rs2 == REG_ZERO)
            w_rs2_val = RESET_VALUE;
        else if (wb_we && wb_wa == w_rs2)
            w_rs2_val = wb_wd;
    end

    // Bundle the decoded fields for capture
    always_comb begin
        w_next         = '0;
        w_next.pc      = bus.in_pc;
        w_next.imm     = w_imm;
        w_next.rs1_val = w_rs1_val;
        w_next.rs2_val = w_rs2_val;
        w_next.rs1     = w_rs1;
        w_next.rs2     = w_rs2;
        w_next.rd      = bus.in_instr[11:7];
        w_next.opcode  = w_opcode;
        w_next.funct3  = bus.in_instr[14:12];
        w_next.funct7  = bus.in_instr[31:25];
        w_next.illegal = !w_legal;
    end

    assign bus.in_ready = !bus.flush
                       && (!r_valid || bus.out_ready);
    assign w_capture    = bus.in_valid && bus.in_ready;
    assign w_stall      = r_valid && !bus.out_ready;

    // Buffer update: rst > flush > capture/drain
    // > refresh of held operands during a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_q     <= w_next;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end else if (w_stall && wb_we
                     && wb_wa != REG_ZERO) begin
            if (wb_wa == r_q.rs1)
                r_q.rs1_val <= wb_wd;
            if (wb_wa == r_q.rs2)
                r_q.rs2_val <= wb_wd;
        end
    end

    assign bus.out_valid   = r_valid;
    assign bus.out_pc      = r_q.pc;
    assign bus.out_imm     = r_q.imm;
    assign bus.out_rs1_val = r_q.rs1_val;
    assign bus.out_rs2_val = r_q.rs2_val;
    assign bus.out_rs1     = r_q.rs1;
    assign bus.out_rs2     = r_q.rs2;
    assign bus.out_rd      = r_q.rd;
    assign bus.out_opcode  = r_q.opcode;
    assign bus.out_funct3  = r_q.funct3;
    assign bus.out_funct7  = r_q.funct7;
    assign bus.out_illegal = r_q.illegal;

endmodule
